// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors, FSM encoding, redirect causes.
package mips_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } fetch_state_t;

    // Ordered so that a numerically larger cause has higher redirect priority.
    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_BR,
        CAUSE_ERET,
        CAUSE_EXC
    } redir_cause_t;

    function automatic redir_cause_t redir_cause(input logic exc, input logic eret, input logic br);
        redir_cause_t c;
        c = CAUSE_NONE;
        if (exc)       c = CAUSE_EXC;
        else if (eret) c = CAUSE_ERET;
        else if (br)   c = CAUSE_BR;
        return c;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// SRAM-like instruction bus: one request handshake (req/addr_ok) and one data return (data_ok).
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/fetch_buf.sv
// One-entry {valid, pc, inst, adel} buffer between fetch and IF/ID.
// Load is visible the cycle after; flush beats load beats consume.
module fetch_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              consume,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [31:0]       load_inst,
    input  logic              load_adel,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       inst,
    output logic              adel
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            adel  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            adel  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
            adel  <= load_adel;
        end else if (consume) begin
            valid <= 1'b0;
            adel  <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, selects next PC, runs one outstanding instruction-bus request.
// Instruction appears in the output buffer one cycle after data_ok; stall_i holds it and blocks refill.
module pc_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
    input  logic              br_i,
    input  logic [ADDR_W-1:0] br_target_i,
    pc_fetch_ctrl_if.master   bus,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
    output logic              if_adel
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] redir_pc, redir_pc_n;
    logic              redir_pend, redir_pend_n;
    redir_cause_t      pend_cause, pend_cause_n;

    redir_cause_t      cause;
    logic              redir;
    logic              take_new;
    logic [ADDR_W-1:0] target;
    logic              aligned;
    logic              can_issue;
    logic              buf_load;
    logic              buf_adel;

    assign cause     = redir_cause(exc_i, eret_i, br_i);
    assign redir     = (cause != CAUSE_NONE);
    assign take_new  = redir && (!redir_pend || (cause >= pend_cause));
    assign aligned   = (pc[1:0] == 2'b00);
    // The buffer must be empty or draining this cycle before new data may land in it.
    assign can_issue = !if_valid || !stall_i;

    always_comb begin
        target = br_target_i;
        if (exc_i)       target = EXC_VEC;
        else if (eret_i) target = epc_i;
    end

    assign bus.inst_addr = pc;
    assign bus.inst_req  = (state == ST_FETCH) && aligned && can_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            redir_pc   <= '0;
            redir_pend <= 1'b0;
            pend_cause <= CAUSE_NONE;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            redir_pc   <= redir_pc_n;
            redir_pend <= redir_pend_n;
            pend_cause <= pend_cause_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        redir_pc_n   = redir_pc;
        redir_pend_n = redir_pend;
        pend_cause_n = pend_cause;
        buf_load     = 1'b0;
        buf_adel     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_n = ST_FETCH;
                if (redir) pc_n = target;
            end
            ST_FETCH: begin
                if (bus.inst_req && bus.inst_addr_ok) begin
                    state_n = ST_WAIT;
                    // Accepted request: its data must still be drained before redirecting.
                    if (redir) begin
                        redir_pend_n = 1'b1;
                        redir_pc_n   = target;
                        pend_cause_n = cause;
                    end
                end else if (redir) begin
                    pc_n = target;
                end else if (!aligned && can_issue) begin
                    buf_load = 1'b1;
                    buf_adel = 1'b1;
                    state_n  = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (take_new) begin
                    redir_pend_n = 1'b1;
                    redir_pc_n   = target;
                    pend_cause_n = cause;
                end
                if (bus.inst_data_ok) begin
                    if (redir_pend || redir) begin
                        pc_n         = take_new ? target : redir_pc;
                        redir_pend_n = 1'b0;
                        pend_cause_n = CAUSE_NONE;
                        state_n      = ST_FETCH;
                    end else begin
                        buf_load = 1'b1;
                        pc_n     = pc + ADDR_W'(4);
                        state_n  = stall_i ? ST_HOLD : ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                // A misaligned PC parks here until something redirects it.
                if (redir) begin
                    pc_n    = target;
                    state_n = ST_FETCH;
                end else if (!stall_i && aligned) begin
                    state_n = ST_FETCH;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .flush     (redir),
        .consume   (if_valid && !stall_i),
        .load_pc   (pc),
        .load_inst (buf_adel ? 32'h0 : bus.inst_rdata),
        .load_adel (buf_adel),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst),
        .adel      (if_adel)
    );

endmodule
